// File: rtl/geofence_driver_if.sv
// Point-stream bundle between the geofence driver (master) and its environment (slave):
// upstream point port, geofence core port and downstream result port.
interface geofence_driver_if;
  logic       pt_valid;
  logic       pt_ready;
  logic [9:0] pt_x;
  logic [9:0] pt_y;
  logic       fence_reset;
  logic [9:0] fence_x;
  logic [9:0] fence_y;
  logic       fence_valid;
  logic       fence_inside;
  logic       res_valid;
  logic       res_ready;
  logic       res_inside;
  logic       res_timeout;

  modport master (
    input  pt_valid, pt_x, pt_y, fence_valid, fence_inside, res_ready,
    output pt_ready, fence_reset, fence_x, fence_y, res_valid, res_inside, res_timeout
  );

  modport slave (
    output pt_valid, pt_x, pt_y, fence_valid, fence_inside, res_ready,
    input  pt_ready, fence_reset, fence_x, fence_y, res_valid, res_inside, res_timeout
  );
endinterface

// File: rtl/geofence_driver.sv
// Buffers one geofence test case (object + 6 vertices), streams it into the core on
// consecutive cycles, then waits for the core result (or a timeout) and reports it.
module geofence_driver #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  geofence_driver_if.master   bus,
  output logic [CNT_W-1:0]    case_count,
  output logic [CNT_W-1:0]    timeout_count
);

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StFill, StStream, StWait, StReport} state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [9:0]        bx_q [7];
  logic [9:0]        bx_d [7];
  logic [9:0]        by_q [7];
  logic [9:0]        by_d [7];
  logic              fence_reset_q, fence_reset_d;
  logic              res_valid_q, res_valid_d;
  logic              res_inside_q, res_inside_d;
  logic              res_timeout_q, res_timeout_d;
  logic [CNT_W-1:0]  case_count_q, case_count_d;
  logic [CNT_W-1:0]  timeout_count_q, timeout_count_d;
  logic              pt_ready;

  // Gated by reset so nothing upstream is consumed while the block is held in reset.
  assign pt_ready = reset && (state_q == StFill);

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    tmo_d           = tmo_q;
    bx_d            = bx_q;
    by_d            = by_q;
    fence_reset_d   = fence_reset_q;
    res_valid_d     = res_valid_q;
    res_inside_d    = res_inside_q;
    res_timeout_d   = res_timeout_q;
    case_count_d    = case_count_q;
    timeout_count_d = timeout_count_q;

    unique case (state_q)
      StFill: begin
        if (bus.pt_valid && pt_ready) begin
          bx_d[idx_q] = bus.pt_x;
          by_d[idx_q] = bus.pt_y;
          if (idx_q == 3'd6) begin
            idx_d         = 3'd0;
            state_d       = StStream;
            fence_reset_d = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StStream: begin
        if (idx_q == 3'd6) begin
          idx_d   = 3'd0;
          tmo_d   = '0;
          state_d = StWait;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      StWait: begin
        tmo_d = tmo_q + 1'b1;
        // A result arriving on the last allowed cycle still counts as a real result.
        if (bus.fence_valid) begin
          res_inside_d  = bus.fence_inside;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          fence_reset_d = 1'b1;
          state_d       = StReport;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          res_inside_d  = 1'b0;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          fence_reset_d = 1'b1;
          state_d       = StReport;
        end
      end
      StReport: begin
        if (bus.res_ready) begin
          res_valid_d  = 1'b0;
          case_count_d = case_count_q + 1'b1;
          if (res_timeout_q) begin
            timeout_count_d = timeout_count_q + 1'b1;
          end
          state_d = StFill;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= StFill;
      idx_q           <= 3'd0;
      tmo_q           <= '0;
      bx_q            <= '{default: '0};
      by_q            <= '{default: '0};
      fence_reset_q   <= 1'b1;
      res_valid_q     <= 1'b0;
      res_inside_q    <= 1'b0;
      res_timeout_q   <= 1'b0;
      case_count_q    <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      tmo_q           <= tmo_d;
      bx_q            <= bx_d;
      by_q            <= by_d;
      fence_reset_q   <= fence_reset_d;
      res_valid_q     <= res_valid_d;
      res_inside_q    <= res_inside_d;
      res_timeout_q   <= res_timeout_d;
      case_count_q    <= case_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign bus.pt_ready    = pt_ready;
  assign bus.fence_reset = fence_reset_q;
  assign bus.fence_x     = (state_q == StStream) ? bx_q[idx_q] : 10'd0;
  assign bus.fence_y     = (state_q == StStream) ? by_q[idx_q] : 10'd0;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_inside  = res_inside_q;
  assign bus.res_timeout = res_timeout_q;
  assign case_count      = case_count_q;
  assign timeout_count   = timeout_count_q;

endmodule

// File: tb/tb_geofence_driver.sv
// Directed bench for geofence_driver with a simple latency model of the geofence core.
module tb_geofence_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] case_count;
  logic [15:0] timeout_count;

  int n_cmp = 0;
  int n_err = 0;

  logic       core_en = 1'b1;
  logic       core_inside = 1'b0;
  logic [7:0] core_cnt = 8'd0;
  logic [9:0] ex [7];
  logic [9:0] ey [7];

  geofence_driver_if bus ();

  geofence_driver #(
    .TIMEOUT (32),
    .CNT_W   (16)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .bus           (bus),
    .case_count    (case_count),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  // Core model: counts cycles out of reset; 7 load cycles, result in the 16th wait cycle.
  always @(posedge clk) begin
    if (bus.fence_reset) core_cnt <= 8'd0;
    else                 core_cnt <= core_cnt + 8'd1;
  end
  assign bus.fence_valid  = core_en && !bus.fence_reset && (core_cnt == 8'd22);
  assign bus.fence_inside = core_inside;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [9:0] x, input logic [9:0] y, input int gap);
    int w;
    repeat (gap) step();
    bus.pt_valid = 1'b1;
    bus.pt_x     = x;
    bus.pt_y     = y;
    w = 0;
    while (!bus.pt_ready && w < 100) begin
      step();
      w++;
    end
    chk("pt_ready_wait", {31'd0, bus.pt_ready}, 32'd1);
    step();
    bus.pt_valid = 1'b0;
    bus.pt_x     = 10'd0;
    bus.pt_y     = 10'd0;
  endtask

  task automatic set_case(input logic [9:0] ox, input logic [9:0] oy);
    ex[0] = ox;    ey[0] = oy;
    ex[1] = 10'd100; ey[1] = 10'd100;
    ex[2] = 10'd300; ey[2] = 10'd100;
    ex[3] = 10'd350; ey[3] = 10'd200;
    ex[4] = 10'd300; ey[4] = 10'd300;
    ex[5] = 10'd100; ey[5] = 10'd300;
    ex[6] = 10'd50;  ey[6] = 10'd200;
  endtask

  task automatic feed(input int npts, input bit gaps);
    for (int k = 0; k < npts; k++) send(ex[k], ey[k], gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  // Expects to be called right after the accepting edge of the 7th point.
  task automatic check_stream(input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("stream_x%0d", k), {22'd0, bus.fence_x}, {22'd0, ex[k]});
      chk($sformatf("stream_y%0d", k), {22'd0, bus.fence_y}, {22'd0, ey[k]});
      chk($sformatf("stream_rst%0d", k), {31'd0, bus.fence_reset}, 32'd0);
      if (k < n - 1) step();
    end
  endtask

  task automatic wait_result(input int exp_lat);
    int w;
    step();
    w = 0;
    while (!bus.res_valid && w < 100) begin
      step();
      w++;
    end
    chk("res_latency", w, exp_lat);
  endtask

  task automatic accept();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("res_valid_drop", {31'd0, bus.res_valid}, 32'd0);
    chk("pt_ready_after", {31'd0, bus.pt_ready}, 32'd1);
  endtask

  initial begin
    bus.pt_valid  = 1'b0;
    bus.pt_x      = 10'd0;
    bus.pt_y      = 10'd0;
    bus.res_ready = 1'b0;

    // 1: reset
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_fence_reset", {31'd0, bus.fence_reset}, 32'd1);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_pt_ready", {31'd0, bus.pt_ready}, 32'd0);
    chk("rst_case_count", {16'd0, case_count}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_pt_ready", {31'd0, bus.pt_ready}, 32'd1);

    // 2: inside case with random gaps
    core_inside = 1'b1;
    set_case(10'd200, 10'd200);
    feed(7, 1'b1);
    check_stream(7);
    wait_result(16);
    chk("c2_inside", {31'd0, bus.res_inside}, 32'd1);
    chk("c2_timeout", {31'd0, bus.res_timeout}, 32'd0);
    accept();
    chk("c2_case_count", {16'd0, case_count}, 32'd1);

    // 3: outside case
    core_inside = 1'b0;
    set_case(10'd500, 10'd500);
    feed(7, 1'b0);
    check_stream(7);
    wait_result(16);
    chk("c3_inside", {31'd0, bus.res_inside}, 32'd0);
    chk("c3_timeout", {31'd0, bus.res_timeout}, 32'd0);
    accept();
    chk("c3_case_count", {16'd0, case_count}, 32'd2);

    // 4: downstream backpressure
    core_inside = 1'b1;
    set_case(10'd250, 10'd200);
    feed(7, 1'b0);
    check_stream(7);
    wait_result(16);
    for (int k = 0; k < 10; k++) begin
      chk("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("bp_res_inside", {31'd0, bus.res_inside}, 32'd1);
      chk("bp_pt_ready", {31'd0, bus.pt_ready}, 32'd0);
      chk("bp_fence_reset", {31'd0, bus.fence_reset}, 32'd1);
      step();
    end
    accept();
    chk("c4_case_count", {16'd0, case_count}, 32'd3);

    // 5: core never answers
    core_en = 1'b0;
    core_inside = 1'b1;
    set_case(10'd200, 10'd200);
    feed(7, 1'b0);
    check_stream(7);
    wait_result(32);
    chk("to_res_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("to_res_timeout", {31'd0, bus.res_timeout}, 32'd1);
    chk("to_res_inside", {31'd0, bus.res_inside}, 32'd0);
    accept();
    chk("to_timeout_count", {16'd0, timeout_count}, 32'd1);
    chk("to_case_count", {16'd0, case_count}, 32'd4);

    // 6: reset in the middle of streaming
    core_en = 1'b1;
    core_inside = 1'b0;
    set_case(10'd210, 10'd190);
    feed(7, 1'b0);
    check_stream(4);
    rst_n = 1'b0;
    step();
    chk("mid_fence_reset", {31'd0, bus.fence_reset}, 32'd1);
    chk("mid_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("mid_case_count", {16'd0, case_count}, 32'd0);
    chk("mid_timeout_count", {16'd0, timeout_count}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    core_inside = 1'b1;
    set_case(10'd150, 10'd250);
    feed(6, 1'b0);
    repeat (3) step();
    chk("partial_fence_reset", {31'd0, bus.fence_reset}, 32'd1);
    chk("partial_fence_x", {22'd0, bus.fence_x}, 32'd0);
    chk("partial_pt_ready", {31'd0, bus.pt_ready}, 32'd1);
    send(ex[6], ey[6], 0);
    check_stream(7);
    wait_result(16);
    chk("c6_inside", {31'd0, bus.res_inside}, 32'd1);
    accept();
    chk("c6_case_count", {16'd0, case_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
